pixel_capture_scaled: RTL
=========================

# pixel_capture_scaled

Parametrised OV7670 capture front end: samples the 8-bit camera bus on `pclk`, assembles two-byte pixels, optionally decimates by a power-of-two factor, and emits 12-bit RGB444 write beats into the frame BRAM. It replaces the fixed 160x120 capture path, sustains one pixel per two `pclk` cycles with no dead cycles, selects RGB444 or RGB565 input per frame, and reports frame completion and line/frame errors to the display/control side.

## Interface
- `H_ACTIVE`, default 160: stored pixels per line (output resolution).
- `V_ACTIVE`, default 120: stored lines per frame.
- `DECIM`, default 4: decimation factor in each axis, legal 1/2/4/8. Input line is `H_ACTIVE*DECIM` pixels; input frame is `V_ACTIVE*DECIM` lines.
- `ADDR_W`, default 15: BRAM address width; must satisfy `2^ADDR_W >= H_ACTIVE*V_ACTIVE`.
- `pclk` in 1: camera pixel clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `D` in 8: camera data bus.
- `vsync` in 1: frame sync, high = blanking.
- `href` in 1: line valid, high = active bytes on `D`.
- `fmt` in 1: 0 = RGB444 (xRGB), 1 = RGB565; sampled on `vsync` fall.
- `RGB` out 12: {R[3:0], G[3:0], B[3:0]}.
- `wr_addr` out ADDR_W: BRAM write address, row-major.
- `wr_en` out 1: one-cycle write strobe.
- `frame_done` out 1: one-cycle pulse on the last write of a frame.
- `err_line` out 1: sticky, line ended short.
- `err_frame` out 1: sticky, `vsync` rose before frame completion.
- `frame_count` out 16: completed-frame counter (see Configuration).

## Operation
- States: WAIT_VS (wait for `vsync` fall), WAIT_LINE, BYTE_HI, BYTE_LO, DONE.
- Reset → WAIT_VS. Capture arms only on a `vsync` 1→0 transition, so a partial frame after reset is never written.
- `vsync` fall: latch `fmt`; clear `col_in`, `row_in`, `line_base`, `wr_addr`; → WAIT_LINE.
- WAIT_LINE: `href`=1 samples `D` as byte 1 in the same cycle → BYTE_LO.
- BYTE_LO: `href`=1 samples byte 2 and forms the pixel → BYTE_HI; `href`=0 → line end (a dangling byte 1 is discarded).
- BYTE_HI: `href`=1 samples byte 1 → BYTE_LO; `href`=0 → line end.
- Pixel kept iff `col_in % DECIM == 0`, `row_in % DECIM == 0`, `col_in < H_ACTIVE*DECIM`, and `row_in < V_ACTIVE*DECIM`. Extra pixels and lines are ignored and do not wrap.
- Color: fmt0 gives R=b1[3:0], G=b2[7:4], B=b2[3:0]. fmt1 gives R=b1[7:4], G={b1[2:0],b2[7]}, B=b2[4:1].
- Address: running counter. `wr_addr` = `line_base` + kept-column index; no multiplier.
- Line end (`href` 1→0 with `col_in` > 0): if the row was a kept row, `line_base` += `H_ACTIVE`. If `col_in` < `H_ACTIVE*DECIM`, set `err_line`. Then `row_in`++, `col_in`=0, → WAIT_LINE.
- Last kept pixel (address `H_ACTIVE*V_ACTIVE-1`) pulses `frame_done` and → DONE. DONE ignores `href` until `vsync` rises.
- `vsync` rise in WAIT_LINE/BYTE_HI/BYTE_LO: abort without `frame_done`, set `err_frame`, → WAIT_VS. In DONE: → WAIT_VS silently.
- `err_*` clear only on `rst`.

## Timing
- `wr_en`, `RGB`, `wr_addr` are registered on the edge that samples byte 2 and are valid together for exactly one cycle.
- Back-to-back kept pixels (`DECIM`=1) give a `wr_en` every second cycle.
- `frame_done` coincides with the final `wr_en`.
- `rst` mid-frame overrides everything: next cycle is WAIT_VS with all outputs at reset values.
- Reset values: `RGB`=0, `wr_addr`=0, `wr_en`=0, `frame_done`=0, `err_line`=0, `err_frame`=0, `frame_count`=0.

## Configuration
- `PIXEL_CAPTURE_FRAME_CNT_EN` defined: `frame_count` increments, wrapping at 16 bits, on each `frame_done`.
- Not defined: counter logic is omitted and `frame_count` is tied to 0. All other behaviour is identical.

## Test plan
- Reset, then frame with `vsync` already low (no fall): no `wr_en` at all; state stays WAIT_VS.
- `DECIM`=1, 4x2 output, fmt0, bytes 0x0A,0xBC per pixel: 8 writes with `RGB`=0xABC, addresses 0..7 every 2nd cycle, `frame_done` with addr 7.
- fmt1, bytes 0xF8,0x1F: `RGB`=0xF0F. Bytes 0x07,0xE0: `RGB`=0x0F0.
- `DECIM`=4, 160x120: exactly 19200 writes, addresses 0..19199, columns 0,4,8… sampled, `frame_done` once, `frame_count`=1 (macro on).
- Line 2 cut to 100 input pixels (`DECIM`=1, `H_ACTIVE`=160): `err_line`=1; line 3's first write lands at addr 320.
- `vsync` rises after row 50: no `frame_done`, `err_frame`=1; next frame restarts at addr 0 and completes normally.

Source files
------------

// File: rtl/pixel_capture_scaled.sv
// pixel_capture_scaled: OV7670 byte-pair capture with power-of-two decimation into RGB444 BRAM writes.
// Define PIXEL_CAPTURE_FRAME_CNT_EN to enable the completed-frame counter on frame_count.
module pixel_capture_scaled #(
  parameter int H_ACTIVE = 160,
  parameter int V_ACTIVE = 120,
  parameter int DECIM = 4,
  parameter int ADDR_W = 15
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic [7:0]        D,
  input  logic              vsync,
  input  logic              href,
  input  logic              fmt,
  output logic [11:0]       RGB,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic              frame_done,
  output logic              err_line,
  output logic              err_frame,
  output logic [15:0]       frame_count
);
  localparam int SH = $clog2(DECIM);
  localparam logic [15:0] H_IN = 16'(H_ACTIVE * DECIM);
  localparam logic [15:0] V_IN = 16'(V_ACTIVE * DECIM);
  localparam logic [15:0] MASK = 16'(DECIM - 1);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  typedef enum logic [2:0] {WAIT_VS, WAIT_LINE, BYTE_HI, BYTE_LO, DONE} state_t;
  state_t state, nxt;
  logic vs_q, fmt_q, vs_fall, vs_rise, ev, in_line, pix, row_keep, keep, last, line_end;
  logic [7:0] b1;
  logic [15:0] col_in, row_in;
  logic [ADDR_W-1:0] line_base, addr;
  logic [11:0] color;
  assign vs_fall = vs_q & ~vsync;
  assign vs_rise = vsync & ~vs_q;
  assign ev = vs_fall | vs_rise;
  assign in_line = state == BYTE_HI || state == BYTE_LO;
  assign pix = !ev && state == BYTE_LO && href;
  assign line_end = !ev && in_line && !href && col_in != 16'd0;
  assign row_keep = (row_in & MASK) == 16'd0 && row_in < V_IN;
  assign keep = pix && row_keep && (col_in & MASK) == 16'd0 && col_in < H_IN;
  // Column offset is a shift because DECIM is a power of two; rows advance by addition.
  assign addr = line_base + ADDR_W'(col_in >> SH);
  assign last = keep && addr == LAST;
  assign color = fmt_q ? {b1[7:4], b1[2:0], D[7], D[4:1]} : {b1[3:0], D};
  always_ff @(posedge pclk)
    state <= rst ? WAIT_VS : nxt;
  always_comb begin
    nxt = state;
    if (vs_fall) nxt = WAIT_LINE;
    else if (vs_rise) nxt = WAIT_VS;
    else if (last) nxt = DONE;
    else if (state == WAIT_LINE || state == BYTE_HI) nxt = href ? BYTE_LO : WAIT_LINE;
    else if (state == BYTE_LO) nxt = href ? BYTE_HI : WAIT_LINE;
  end
  always_ff @(posedge pclk)
    if (rst) begin
      vs_q <= 1'b0;
      fmt_q <= 1'b0;
      b1 <= 8'd0;
      col_in <= 16'd0;
      row_in <= 16'd0;
      line_base <= '0;
      RGB <= 12'd0;
      wr_addr <= '0;
      wr_en <= 1'b0;
      frame_done <= 1'b0;
      err_line <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      vs_q <= vsync;
      wr_en <= keep;
      frame_done <= last;
      if (keep) begin
        RGB <= color;
        wr_addr <= addr;
      end
      if (state == WAIT_LINE || state == BYTE_HI) b1 <= D;
      if (vs_rise && (in_line || state == WAIT_LINE)) err_frame <= 1'b1;
      if (vs_fall) begin
        fmt_q <= fmt;
        col_in <= 16'd0;
        row_in <= 16'd0;
        line_base <= '0;
        wr_addr <= '0;
      end else if (line_end) begin
        if (row_keep) line_base <= line_base + H_STEP;
        if (col_in < H_IN) err_line <= 1'b1;
        if (row_in != 16'hFFFF) row_in <= row_in + 16'd1;
        col_in <= 16'd0;
      end else if (pix && col_in != 16'hFFFF) col_in <= col_in + 16'd1;
    end
`ifdef PIXEL_CAPTURE_FRAME_CNT_EN
  always_ff @(posedge pclk)
    frame_count <= rst ? 16'd0 : frame_count + {15'd0, last};
`else
  assign frame_count = 16'd0;
`endif
endmodule
